// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    // Index of the hardwired zero register.
    localparam int REG_ZERO = 0;

    // Bit offset of read port k inside a flattened bus of w-bit fields.
    function automatic int rd_off(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue wins ties.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_sel,
    input  logic                  wr0_en,
    input  logic [ADDR_W-1:0]     wr0_sel,
    input  logic                  wr1_en,
    input  logic [ADDR_W-1:0]     wr1_sel,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [CNT_W-1:0] busy_cnt_q;
    logic [CNT_W-1:0] busy_cnt_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bit
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            logic bit_d;

            // Next busy state for one register: issue beats clear, otherwise hold.
            always_comb begin
                bit_d = busy_q[gi];
                if ((wr0_en && wr0_sel == IDX) || (wr1_en && wr1_sel == IDX)) begin
                    bit_d = 1'b0;
                end
                if (iss_en && iss_sel == IDX) begin
                    bit_d = 1'b1;
                end
                if (ZERO_REG && gi == REG_ZERO) begin
                    bit_d = 1'b0;
                end
            end

            assign busy_d[gi] = bit_d;
        end
    endgenerate

    // Population count of the next busy vector so the count tracks it exactly.
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
        end
    end

    // Busy vector and count registers; reset discards all pending writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with dual writeback, optional bypass, zero register
// and a busy scoreboard used by decode for hazard stalls.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_sel,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_sel,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_sel,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZSEL = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr0_ok;
    logic              wr1_ok;

    // Writes aimed at the hardwired zero register are dropped.
    always_comb begin
        wr0_ok = wr0_en && !(ZERO_REG && wr0_sel == ZSEL);
        wr1_ok = wr1_en && !(ZERO_REG && wr1_sel == ZSEL);
    end

    // Next array contents: port 1 applied last so it wins a same-register collision.
    always_comb begin
        mem_d = mem_q;
        if (wr0_ok) begin
            mem_d[wr0_sel] = wr0_data;
        end
        if (wr1_ok) begin
            mem_d[wr1_sel] = wr1_data;
        end
    end

    // Register array; reset clears every entry and overrides same-cycle writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_sel  (iss_sel),
        .wr0_en   (wr0_en),
        .wr0_sel  (wr0_sel),
        .wr1_en   (wr1_en),
        .wr1_sel  (wr1_sel),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] port_sel;
            logic [DATA_W-1:0] port_data;
            logic              port_busy;
            logic              hit0;
            logic              hit1;

            assign port_sel = rd_sel[rd_off(gi, ADDR_W) +: ADDR_W];

            // Read mux: stored value, then bypass (port 1 first), then zero-register override.
            always_comb begin
                hit0      = BYPASS && wr0_en && (wr0_sel == port_sel);
                hit1      = BYPASS && wr1_en && (wr1_sel == port_sel);
                port_data = mem_q[port_sel];
                port_busy = busy[port_sel];
                if (hit1) begin
                    port_data = wr1_data;
                    port_busy = 1'b0;
                end else if (hit0) begin
                    port_data = wr0_data;
                    port_busy = 1'b0;
                end
                if (ZERO_REG && port_sel == ZSEL) begin
                    port_data = '0;
                    port_busy = 1'b0;
                end
            end

            assign rd_data[rd_off(gi, DATA_W) +: DATA_W] = port_data;
            assign rd_busy[gi]                           = port_busy;
        end
    endgenerate

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port register file for the pipelined RISC core, successor to the single-write/two-read file.
- Adds:
  - configurable width, depth and read-port count
  - two write ports (ALU and load writeback)
  - optional write-to-read bypass
  - hardwired zero register
  - per-register busy scoreboard that the decode stage uses for hazard stalls
- Sits between decode (reads, issue marking) and writeback (writes, busy clear).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, select width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and issues
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- rd_sel  in  NUM_RD*ADDR_W  read selects; port k = bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational, port k = [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  1 = selected register has a pending write (after bypass/clear rules)
- wr0_en  in  1  write port 0 enable (ALU writeback)
- wr0_sel  in  ADDR_W  write port 0 destination
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 enable (load writeback), priority over port 0
- wr1_sel  in  ADDR_W  write port 1 destination
- wr1_data  in  DATA_W  write port 1 data
- iss_en  in  1  mark iss_sel busy (instruction issued with destination)
- iss_sel  in  ADDR_W  destination being issued
- busy_cnt  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset: synchronous, active-high, clock = clock. On a reset edge all registers <= 0, all busy bits <= 0, busy_cnt <= 0. Reset overrides any same-cycle write or issue.
- Outputs after reset: rd_data = 0 on every port, rd_busy = 0, busy_cnt = 0.
- Write: on rising edge, wrN_en=1 stores wrN_data into wrN_sel.
  - Both ports targeting the same register: port 1 wins, port 0 is dropped.
  - Different registers: both are written.
- Read: rd_data is combinational from the array. Latency 0 for stored values.
- Bypass (BYPASS=1): if rd_sel matches an enabled write port in the same cycle, rd_data = that port's data.
  - Port 1 beats port 0 on a double match.
  - BYPASS=0: the new value is visible the cycle after the write.
- Zero register (ZERO_REG=1):
  - rd_data for select 0 is always 0, including under bypass.
  - Writes to register 0 are ignored.
  - iss_en with iss_sel=0 does not set busy.
  - rd_busy for select 0 is always 0.
- Scoreboard: busy[r] next-state, applied in priority order:
  - reset -> 0
  - iss_en && iss_sel==r -> 1 (a new issue beats a same-cycle writeback to the same register)
  - (wr0_en && wr0_sel==r) or (wr1_en && wr1_sel==r) -> 0
  - otherwise hold
- rd_busy[k]:
  - equals busy[rd_sel_k], masked to 0 when BYPASS=1 and a same-cycle write targets rd_sel_k (the data is forwarded).
  - Issue in the current cycle does not affect rd_busy until the next cycle.
- busy_cnt: registered population count of the busy vector, updated with it. Range 0..2**ADDR_W (ADDR_W+1 bits), never wraps.
- Write to a non-busy register: data is stored, busy stays 0. Legal; not an error.
- Reset mid-operation: pending busy bits are discarded; the core flushes the pipeline on reset.

Decomposition:
- Package regfile_pkg:
  - default DATA_W / ADDR_W / NUM_RD constants
  - REG_ZERO index constant
  - a function for read-port slice offsets
- Sub-module regfile_scoreboard:
  - owns the busy vector, issue/clear priority and busy_cnt
  - inputs: clock, reset, iss, both write enables/selects
  - output: busy vector
- The top level holds the data array, the bypass muxes and the per-port busy masking.

Test Plan:
- Reset, then read all 32 selects on both ports -> every rd_data=0, rd_busy=0, busy_cnt=0.
- wr0 r5=0xDEADBEEF, next cycle read r5 -> 0xDEADBEEF. With BYPASS=1, the same-cycle read of r5 also returns 0xDEADBEEF.
- wr0 r7=0x11 and wr1 r7=0x22 in the same cycle -> r7 reads 0x22 next cycle; a bypassed same-cycle read also returns 0x22.
- iss r3, then iss r4 -> busy_cnt 1 then 2, rd_busy for r3=1. Then wr1 r3=0x55 -> rd_busy r3=0 that cycle (bypass), busy_cnt=1 next cycle.
- Same cycle: iss r9 and wr0 r9 -> r9 data updated, busy[r9]=1, busy_cnt incremented. Write to r0=0xFFFF plus iss r0 -> r0 reads 0, busy_cnt unchanged.
- Set 3 busy registers, assert reset together with wr0 r2=0x99 -> all registers 0, busy_cnt=0, r2 reads 0.
